// File: rtl/alu_181_seq.sv
// rtl/alu_181_seq.sv - slice-serial 74181-style ALU (optional flags: ALU_FLAGS_EN)
module alu_181_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn,
    output logic [WIDTH-1:0] f,
    output logic             co_n,
    output logic             aeqb,
    output logic             out_valid,
    input  logic             out_ready
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       s_q;
    logic             m_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] f_q;
    logic             co_n_q;

    logic [WIDTH-1:0] x_full;
    logic [WIDTH-1:0] y_full;
    logic [SLICE-1:0] x_sl;
    logic [SLICE-1:0] y_sl;
    logic [SLICE:0]   sum_sl;
    logic [SLICE-1:0] res_sl;
    logic [WIDTH-1:0] f_d;
    logic             last_slice;

`ifdef ALU_FLAGS_EN
    logic zero_q;
    logic neg_q;
    logic ovf_q;
    logic ovf_d;
`endif

    // 74181 propagate/generate-style operand terms over the captured operands
    always_comb begin
        x_full = a_q | (s_q[0] ? b_q : '0) | (s_q[1] ? ~b_q : '0);
        y_full = (s_q[2] ? (a_q & ~b_q) : '0) | (s_q[3] ? (a_q & b_q) : '0);
    end

    // Current slice: select, add with rippled carry or apply logic function
    always_comb begin
        x_sl       = x_full[idx_q*SLICE +: SLICE];
        y_sl       = y_full[idx_q*SLICE +: SLICE];
        sum_sl     = {1'b0, x_sl} + {1'b0, y_sl} + {{SLICE{1'b0}}, carry_q};
        res_sl     = m_q ? ~(x_sl ^ y_sl) : sum_sl[SLICE-1:0];
        last_slice = (idx_q == IW'(NSLICE - 1));
        f_d        = f_q;
        f_d[idx_q*SLICE +: SLICE] = res_sl;
    end

`ifdef ALU_FLAGS_EN
    // Overflow: carry into MSB (recovered from the MSB sum bit) xor carry out
    always_comb begin
        ovf_d = ~m_q & (x_sl[SLICE-1] ^ y_sl[SLICE-1] ^ sum_sl[SLICE-1] ^ sum_sl[SLICE]);
    end
`endif

    // Control FSM with operand capture and slice-serial result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            f_q     <= '0;
            co_n_q  <= 1'b1;
`ifdef ALU_FLAGS_EN
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        s_q     <= s;
                        m_q     <= m;
                        carry_q <= ~cn;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    f_q     <= f_d;
                    carry_q <= sum_sl[SLICE];
                    idx_q   <= idx_q + 1'b1;
                    if (last_slice) begin
                        co_n_q  <= m_q ? 1'b1 : ~sum_sl[SLICE];
`ifdef ALU_FLAGS_EN
                        zero_q  <= (f_d == '0);
                        neg_q   <= f_d[WIDTH-1];
                        ovf_q   <= ovf_d;
`endif
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output mapping; in_ready is masked by reset so nothing is taken during it
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        f         = f_q;
        co_n      = co_n_q;
        aeqb      = &f_q;
`ifdef ALU_FLAGS_EN
        zero      = zero_q;
        neg       = neg_q;
        ovf       = ovf_q;
`endif
    end

endmodule

// File: tb/tb_alu_181_seq.sv
// tb/tb_alu_181_seq.sv - directed table-driven bench for alu_181_seq
module tb_alu_181_seq;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             cn;
    logic [WIDTH-1:0] f;
    logic             co_n;
    logic             aeqb;
    logic             out_valid;
    logic             out_ready;
`ifdef ALU_FLAGS_EN
    logic             zero;
    logic             neg;
    logic             ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_181_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .m         (m),
        .cn        (cn),
        .f         (f),
        .co_n      (co_n),
        .aeqb      (aeqb),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ALU_FLAGS_EN
        ,
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  s;
        logic        m;
        logic        cn;
        logic [15:0] ef;
        logic        eco;
        logic        eaeqb;
        logic        ez;
        logic        en;
        logic        eo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation, wait for the result, check it, then hand it off
    task automatic run_op(input vec_t v, input int id);
        int cycles;
        @(negedge clk);
        a = v.a; b = v.b; s = v.s; m = v.m; cn = v.cn;
        in_valid = 1'b1;
        chk($sformatf("v%0d in_ready_idle", id), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a = ~v.a; b = ~v.b; s = ~v.s; cn = ~v.cn;
        chk($sformatf("v%0d in_ready_run", id), 32'(in_ready), 32'd0);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        chk($sformatf("v%0d latency", id), 32'(cycles), 32'(NSLICE));
        chk($sformatf("v%0d f", id), 32'(f), 32'(v.ef));
        chk($sformatf("v%0d co_n", id), 32'(co_n), 32'(v.eco));
        chk($sformatf("v%0d aeqb", id), 32'(aeqb), 32'(v.eaeqb));
`ifdef ALU_FLAGS_EN
        chk($sformatf("v%0d zero", id), 32'(zero), 32'(v.ez));
        chk($sformatf("v%0d neg", id), 32'(neg), 32'(v.en));
        chk($sformatf("v%0d ovf", id), 32'(ovf), 32'(v.eo));
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("v%0d out_valid_drop", id), 32'(out_valid), 32'd0);
        chk($sformatf("v%0d in_ready_back", id), 32'(in_ready), 32'd1);
    endtask

    initial begin
        int cycles;
        int seen;
        //           a        b        s        m     cn    ef       eco   eaeqb ez    en    eo
        vecs[0]  = '{16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 16'h2233, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{16'h0005, 16'h0007, 4'b0110, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{16'h0007, 16'h0005, 4'b0110, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0, 16'h0FF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'hF0F0, 16'hFF00, 4'b1100, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{16'h1000, 16'h1234, 4'b1111, 1'b0, 1'b1, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'h0005, 16'h0009, 4'b0011, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{16'h1234, 16'h5678, 4'b0000, 1'b1, 1'b1, 16'hEDCB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; s = '0; m = 1'b0; cn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst f", 32'(f), 32'd0);
        chk("rst co_n", 32'(co_n), 32'd1);
`ifdef ALU_FLAGS_EN
        chk("rst zero", 32'(zero), 32'd0);
        chk("rst neg", 32'(neg), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("post_rst in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], i);
        end

        // Backpressure: result held while out_ready low, new requests ignored
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; s = 4'b1001; m = 1'b0; cn = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        chk("bp latency", 32'(cycles), 32'(NSLICE));
        a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d f", i), 32'(f), 32'h2233);
            chk($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp in_ready_back", 32'(in_ready), 32'd1);
        chk("bp out_valid_drop", 32'(out_valid), 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("bp ignored_request", 32'(seen), 32'd0);

        // Reset during the second RUN cycle discards the operation
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; s = 4'b1001; m = 1'b0; cn = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst f", 32'(f), 32'd0);
        chk("mid_rst co_n", 32'(co_n), 32'd1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid_rst no_result", 32'(seen), 32'd0);
        chk("mid_rst idle", 32'(in_ready), 32'd1);

        // Normal operation resumes after the aborted one
        run_op(vecs[4], 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
